// File: rtl/uart_rx_fifo.sv
// UART receiver (5..8 data bits, none/odd/even parity, 1..2 stop bits) with
// 3-sample majority-vote bit detection feeding a circular character FIFO.
module uart_rx_fifo #(
    parameter int CLK_FRQ         = 0,
    parameter int BAUD_RATE       = 0,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_in,
    output logic [DATA_BITS-1:0]       rx_data,
    output logic                       rx_frame_err,
    output logic                       rx_parity_err,
    output logic                       rx_data_ready,
    input  logic                       rx_read,
    output logic [FIFO_DEPTH_LOG2:0]   rx_count,
    output logic                       rx_overrun,
    input  logic                       rx_clear_err
);
    // Default parameters give a zero baud rate; clamp so elaboration stays sane.
    localparam int BAUD_SAFE = (BAUD_RATE > 0) ? BAUD_RATE : 1;
    localparam int CYCLE_RAW = CLK_FRQ / BAUD_SAFE;
    localparam int CYCLE     = (CYCLE_RAW < 8) ? 8 : CYCLE_RAW;
    localparam int HALF      = CYCLE / 2;
    localparam int CW        = $clog2(CYCLE);
    localparam int AW        = FIFO_DEPTH_LOG2;
    localparam int DEPTH     = 1 << AW;
    localparam int EW        = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic                 r_sync1, r_sync2, r_sync_d;
    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [2:0]           r_bit_idx, w_bit_nxt;
    logic                 r_stop_idx, w_stop_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par_err, w_par_nxt;
    logic                 r_frm_err, w_frm_nxt;
    logic                 r_samp0, r_samp1;
    logic                 w_fall, w_mid, w_end, w_maj, w_par_exp, w_frm_fin, w_push;

    // Synchroniser and edge-history flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= rx_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_fall    = r_sync_d & ~r_sync2;
    assign w_mid     = (r_cnt == CW'(HALF));
    assign w_end     = (r_cnt == CW'(CYCLE - 1));
    assign w_maj     = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);
    assign w_par_exp = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
    assign w_frm_fin = r_frm_err | ~w_maj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_samp0    <= 1'b1;
            r_samp1    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_stop_idx <= w_stop_nxt;
            r_shift    <= w_shift_nxt;
            r_par_err  <= w_par_nxt;
            r_frm_err  <= w_frm_nxt;
            if (r_cnt == CW'(HALF - 2)) r_samp0 <= r_sync2;
            if (r_cnt == CW'(HALF - 1)) r_samp1 <= r_sync2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_end ? '0 : r_cnt + CW'(1);
        w_bit_nxt   = r_bit_idx;
        w_stop_nxt  = r_stop_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par_err;
        w_frm_nxt   = r_frm_err;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_par_nxt   = 1'b0;
                    w_frm_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_mid && w_maj) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_mid) w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
                if (w_end) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_mid) w_par_nxt = (w_maj != w_par_exp);
                if (w_end) begin
                    w_state_nxt = S_STOP;
                    w_stop_nxt  = 1'b0;
                end
            end
            S_STOP: begin
                // Leave half a bit early on the last stop bit to resync on the next start edge.
                if (w_mid) begin
                    w_frm_nxt = w_frm_fin;
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_end) begin
                    w_stop_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr, r_rptr, w_count;
    logic          w_empty, w_full, w_do_pop, w_do_push;
    logic [EW-1:0] w_head, w_wr_entry;
    logic          r_overrun;

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == (AW+1)'(DEPTH));
    assign w_do_pop   = rx_read & ~w_empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign w_do_push  = w_push & (~w_full | w_do_pop);
    assign w_wr_entry = {w_frm_fin, r_par_err, r_shift};
    assign w_head     = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= w_wr_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
            if (w_push && w_full && !w_do_pop) r_overrun <= 1'b1;
            else if (rx_clear_err)             r_overrun <= 1'b0;
        end
    end

    assign rx_data       = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign rx_parity_err = w_empty ? 1'b0 : w_head[DATA_BITS];
    assign rx_frame_err  = w_empty ? 1'b0 : w_head[DATA_BITS+1];
    assign rx_data_ready = ~w_empty;
    assign rx_count      = w_count;
    assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: four differently configured receivers, directed frames
// plus random traffic, checked against a queue-based character model.
module tb_uart_rx_fifo;
    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rx, rd, clr;
    wire  [3:0] rdy, fe, pe, ovr;
    wire  [7:0] dat [4];
    wire  [4:0] cnt [4];
    wire  [6:0] dat1, dat2;
    wire  [2:0] cnt3;

    assign dat[1] = {1'b0, dat1};
    assign dat[2] = {1'b0, dat2};
    assign cnt[3] = {2'b00, cnt3};

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_FRQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH_LOG2(4)) u0 (
        .clk(clk), .reset(rst), .rx_in(rx[0]), .rx_data(dat[0]), .rx_frame_err(fe[0]),
        .rx_parity_err(pe[0]), .rx_data_ready(rdy[0]), .rx_read(rd[0]), .rx_count(cnt[0]),
        .rx_overrun(ovr[0]), .rx_clear_err(clr[0]));
    uart_rx_fifo #(.CLK_FRQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH_LOG2(4)) u1 (
        .clk(clk), .reset(rst), .rx_in(rx[1]), .rx_data(dat1), .rx_frame_err(fe[1]),
        .rx_parity_err(pe[1]), .rx_data_ready(rdy[1]), .rx_read(rd[1]), .rx_count(cnt[1]),
        .rx_overrun(ovr[1]), .rx_clear_err(clr[1]));
    uart_rx_fifo #(.CLK_FRQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH_LOG2(4)) u2 (
        .clk(clk), .reset(rst), .rx_in(rx[2]), .rx_data(dat2), .rx_frame_err(fe[2]),
        .rx_parity_err(pe[2]), .rx_data_ready(rdy[2]), .rx_read(rd[2]), .rx_count(cnt[2]),
        .rx_overrun(ovr[2]), .rx_clear_err(clr[2]));
    uart_rx_fifo #(.CLK_FRQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH_LOG2(2)) u3 (
        .clk(clk), .reset(rst), .rx_in(rx[3]), .rx_data(dat[3]), .rx_frame_err(fe[3]),
        .rx_parity_err(pe[3]), .rx_data_ready(rdy[3]), .rx_read(rd[3]), .rx_count(cnt3),
        .rx_overrun(ovr[3]), .rx_clear_err(clr[3]));

    // Model: per receiver, a queue of {frame_err, parity_err, data[7:0]} and a sticky overrun.
    int         nb  [4] = '{8, 7, 7, 8};
    int         pm  [4] = '{0, 2, 1, 0};
    int         sb  [4] = '{1, 2, 1, 1};
    int         dep [4] = '{16, 16, 16, 4};
    logic [9:0] mq  [4][$];
    bit         mo  [4];
    int         ncmp = 0;
    int         nerr = 0;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic check(input int idx);
        logic [9:0] h;
        chk("count", idx, 32'(cnt[idx]), 32'(mq[idx].size()));
        chk("ready", idx, 32'(rdy[idx]), 32'(mq[idx].size() > 0));
        chk("overrun", idx, 32'(ovr[idx]), 32'(mo[idx]));
        if (mq[idx].size() > 0) begin
            h = mq[idx][0];
            chk("data", idx, 32'(dat[idx]), 32'(h[7:0]));
            chk("parity_err", idx, 32'(pe[idx]), 32'(h[8]));
            chk("frame_err", idx, 32'(fe[idx]), 32'(h[9]));
        end
    endtask

    task automatic idle(input int idx, input int n);
        rx[idx] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop(input int idx);
        rd[idx] = 1'b1;
        @(posedge clk); #1;
        rd[idx] = 1'b0;
        if (mq[idx].size() > 0) void'(mq[idx].pop_front());
    endtask

    task automatic clear(input int idx);
        clr[idx] = 1'b1;
        @(posedge clk); #1;
        clr[idx] = 1'b0;
        mo[idx] = 1'b0;
    endtask

    // Send one frame; flip inverts the correct parity bit, stops gives the stop-bit levels.
    // rd_push raises rx_read for exactly the cycle in which the character is pushed.
    // abort_at >= 0 stops mid-bit at that frame bit index without updating the model.
    task automatic send(input int idx, input logic [7:0] d, input bit flip, input logic [1:0] stops,
                        input bit rd_push, input int abort_at);
        logic [15:0] bits;
        logic [7:0]  dm;
        logic        par;
        bit          fe_m;
        int          n;
        dm      = d & 8'((1 << nb[idx]) - 1);
        bits    = '1;
        bits[0] = 1'b0;
        n       = 1;
        for (int i = 0; i < nb[idx]; i++) begin bits[n] = dm[i]; n++; end
        if (pm[idx] != 0) begin
            par = ($countones(dm) % 2) == 1;
            if (pm[idx] == 1) par = !par;
            bits[n] = par ^ flip;
            n++;
        end
        fe_m = 1'b0;
        for (int i = 0; i < sb[idx]; i++) begin
            bits[n] = stops[i];
            if (!stops[i]) fe_m = 1'b1;
            n++;
        end
        for (int j = 0; j < n; j++) begin
            rx[idx] = bits[j];
            if (j == abort_at) begin
                repeat (C/2) @(posedge clk);
                #1;
                return;
            end else if (j == n - 1 && rd_push) begin
                repeat (C/2 + 3) @(posedge clk);
                #1; rd[idx] = 1'b1;
                @(posedge clk); #1; rd[idx] = 1'b0;
                repeat (C - C/2 - 4) @(posedge clk);
                #1;
            end else begin
                repeat (C) @(posedge clk);
                #1;
            end
        end
        if (rd_push && mq[idx].size() > 0) void'(mq[idx].pop_front());
        if (mq[idx].size() < dep[idx]) mq[idx].push_back({fe_m, (pm[idx] != 0) && flip, dm});
        else mo[idx] = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [1:0] st;
        bit         fl, rp;
        rst = 1'b1; rx = '1; rd = '0; clr = '0;
        for (int i = 0; i < 4; i++) mo[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check(i);
        chk("reset_data", 0, 32'(dat[0]), 32'h0);
        rst = 1'b0;
        idle(0, 2 * C);

        // 8N1 two characters, then drain
        send(0, 8'h55, 0, 2'b11, 0, -1);
        send(0, 8'hA3, 0, 2'b11, 0, -1);
        chk("t1_count", 0, 32'(cnt[0]), 32'd2);
        check(0);
        pop(0); check(0);
        chk("t1_head2", 0, 32'(dat[0]), 32'hA3);
        pop(0); check(0);
        pop(0); check(0);

        // 7-bit even and odd parity
        send(1, 8'h41, 0, 2'b11, 0, -1);
        chk("t2_even_ok", 1, 32'(pe[1]), 32'd0);
        pop(1);
        send(1, 8'h41, 1, 2'b11, 0, -1);
        chk("t2_even_bad", 1, 32'(pe[1]), 32'd1);
        check(1); pop(1);
        send(2, 8'h41, 0, 2'b11, 0, -1);
        chk("t2_odd_ok", 2, 32'(pe[2]), 32'd0);
        check(2); pop(2);

        // low stop bit, then a clean frame
        send(0, 8'h3C, 0, 2'b00, 0, -1);
        chk("t3_frame_err", 0, 32'(fe[0]), 32'd1);
        check(0);
        idle(0, C);
        send(0, 8'h3C, 0, 2'b11, 0, -1);
        pop(0); check(0);
        chk("t3_frame_ok", 0, 32'(fe[0]), 32'd0);
        pop(0);

        // 3-clock glitch must not push
        rx[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(0, 2 * C);
        check(0);
        send(0, 8'h7E, 0, 2'b11, 0, -1);
        check(0); pop(0);

        // break: a single frame-error entry, no re-trigger while held low
        rx[0] = 1'b0;
        repeat (30 * C) @(posedge clk);
        #1;
        mq[0].push_back({1'b1, 1'b0, 8'h00});
        idle(0, C);
        check(0); pop(0); check(0);

        // overrun on a depth-4 FIFO, clear, then read exactly on a full push
        for (int i = 1; i <= 5; i++) send(3, 8'(i), 0, 2'b11, 0, -1);
        chk("t5_overrun", 3, 32'(ovr[3]), 32'd1);
        check(3);
        clear(3); check(3);
        send(3, 8'h06, 0, 2'b11, 1, -1);
        chk("t5_count_full", 3, 32'(cnt[3]), 32'd4);
        check(3);
        for (int i = 0; i < 4; i++) begin pop(3); check(3); end

        // random traffic on every receiver
        for (int idx = 0; idx < 4; idx++) begin
            for (int k = 0; k < 12; k++) begin
                d  = 8'($urandom);
                fl = ($urandom_range(0, 3) == 0);
                st = 2'b11;
                if ($urandom_range(0, 5) == 0) st[$urandom_range(0, sb[idx] - 1)] = 1'b0;
                rp = ($urandom_range(0, 4) == 0);
                send(idx, d, fl, st, rp, -1);
                check(idx);
                if (st != 2'b11) idle(idx, C + $urandom_range(0, 5));
                else idle(idx, $urandom_range(0, 5));
                for (int p = $urandom_range(0, 2); p > 0; p--) begin pop(idx); check(idx); end
            end
            while (mq[idx].size() > 0) pop(idx);
            if (mo[idx]) clear(idx);
            check(idx);
        end

        // asynchronous reset mid-frame with entries queued
        send(0, 8'h11, 0, 2'b11, 0, -1);
        send(0, 8'h22, 0, 2'b11, 0, -1);
        check(0);
        send(0, 8'h96, 0, 2'b11, 0, 4);
        rst = 1'b1;
        #1;
        chk("t6_ready", 0, 32'(rdy[0]), 32'd0);
        chk("t6_count", 0, 32'(cnt[0]), 32'd0);
        chk("t6_data", 0, 32'(dat[0]), 32'd0);
        chk("t6_errs", 0, 32'({fe[0], pe[0], ovr[0]}), 32'd0);
        for (int i = 0; i < 4; i++) begin mq[i].delete(); mo[i] = 1'b0; end
        rx[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(0, C);
        send(0, 8'h96, 0, 2'b11, 0, -1);
        chk("t6_sole", 0, 32'(cnt[0]), 32'd1);
        check(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a configurable frame format (5–8 data bits, none/odd/even parity, 1 or 2 stop bits) and a 3-sample majority-vote bit detector. Received characters, with per-character framing and parity error flags, are written into an internal FIFO. The block replaces the single-byte receiver on the console/serial path. It lets the bus-side logic drain several characters per poll and detect lost data.

## Interface
- CLK_FRQ, 0, clock frequency in Hz
- BAUD_RATE, 0, serial baud rate; CYCLE = CLK_FRQ/BAUD_RATE, must be >= 8
- DATA_BITS, 8, data bits per frame, 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH_LOG2, 4, FIFO holds 2^FIFO_DEPTH_LOG2 entries

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- rx_in  input  1  serial input, idle high, asynchronous to clk
- rx_data  output  DATA_BITS  FIFO head data, LSB = first received bit
- rx_frame_err  output  1  head entry had a low stop bit
- rx_parity_err  output  1  head entry had a parity mismatch (always 0 when PARITY = 0)
- rx_data_ready  output  1  FIFO not empty
- rx_read  input  1  pop head entry; ignored when empty
- rx_count  output  FIFO_DEPTH_LOG2+1  number of entries held
- rx_overrun  output  1  sticky: a character was dropped because the FIFO was full
- rx_clear_err  input  1  clears rx_overrun

## Operation
- rx_in passes through a 2-flop synchroniser. Both flops reset to 1, so reset never produces a false start.
- Falling-edge detect on the synchronised line, evaluated in IDLE only.
- FSM states: IDLE, START, DATA, PARITY, STOP. cycle_cnt counts 0..CYCLE-1 within each bit and restarts at every bit boundary.
- Bit value = majority of the samples taken at cycle_cnt = CYCLE/2-2, CYCLE/2-1 and CYCLE/2. The bit is decided at CYCLE/2.
- IDLE -> START on a falling edge; cycle_cnt = 0.
- START: if the majority value is 1 at mid-bit, it is a false start and the FSM returns to IDLE with no push. Otherwise the FSM moves to DATA at the end of the bit.
- DATA: shifts DATA_BITS bits, LSB first, then goes to PARITY if PARITY != 0, otherwise to STOP.
- PARITY: compares the sampled bit against odd/even parity of the data and latches parity_err.
- STOP: samples each stop bit; frame_err = OR of (stop bit == 0). When STOP_BITS = 2, the first stop bit runs a full bit period.
- On the decision cycle (CYCLE/2) of the last stop bit, the FSM pushes {frame_err, parity_err, data} and returns to IDLE. This half-bit early return is intentional, for resynchronisation.
- A break (line held low) produces one frame_err entry. A new start requires the line to go high and then low again.
- FIFO behaviour:
  - Circular buffer with wrapping read/write pointers; rx_count = writes − reads.
  - Head outputs are valid whenever rx_data_ready = 1, with no read latency. Their value is don't-care when empty.
  - Push when full without a same-cycle rx_read: the character is dropped, FIFO contents are unchanged, and rx_overrun is set.
  - Push and rx_read in the same cycle, whether full or not: both happen, rx_count is unchanged, no overrun.
  - rx_read when empty: no effect.
  - rx_clear_err in the same cycle as a new overrun: the set wins.

## Timing
- Reset values: rx_data, rx_frame_err, rx_parity_err, rx_data_ready, rx_count and rx_overrun = 0; FIFO empty; FSM = IDLE.
- Reset asserted mid-frame abandons the frame and flushes the FIFO, taking effect immediately (asynchronous).
- Latency: rx_data_ready rises, or rx_count increments, on the clock edge after the last stop-bit decision cycle.
- rx_read pop: rx_count decrements and the next entry appears on the head outputs on the following edge.
- Edge-to-start detect latency is 3 clocks (synchroniser plus edge detector). This offset is constant per frame and absorbed by the mid-bit sampling.
- Baud tolerance: the sample point is mid-bit. An 8N1 frame tolerates ±4% clock mismatch.

## Test plan
All tests use CLK_FRQ=1_000_000, BAUD_RATE=100_000 (CYCLE=10).

1. 8N1: send 0x55 then 0xA3 with no reads -> rx_count=2; head=0x55 with errors 0; after rx_read head=0xA3; after a second read rx_data_ready=0.
2. DATA_BITS=7, PARITY=2: send 0x41 with parity bit 0 -> rx_parity_err=0. Repeat with parity bit 1 -> data 0x41, rx_parity_err=1. With PARITY=1 and parity bit 1 -> rx_parity_err=0.
3. 8N1: send 0x3C with the stop bit driven low -> entry 0x3C with rx_frame_err=1. Raise the line, send 0x3C with a valid frame -> rx_frame_err=0.
4. Glitch: rx_in low for 3 clocks, then high -> no push, FSM back in IDLE. A following 0x7E is received correctly.
5. FIFO_DEPTH_LOG2=2: send 5 bytes 0x01..0x05 with no reads -> rx_count=4, head=0x01, rx_overrun=1, 0x05 lost. Pulse rx_clear_err -> rx_overrun=0. Assert rx_read exactly on the push cycle of a 6th byte 0x06 while full -> rx_count stays 4, rx_overrun stays 0, last entry = 0x06.
6. Assert reset at DATA bit 3 of 0x96 with 2 entries queued -> all outputs 0 immediately. After release, 0x96 is received as the sole entry.
